aibcr3_txdat_gearbox: RTL and testbench

- Parallel-to-DDR gearbox sitting directly upstream of the AIB TX IO digital stage.
- Accepts DWIDTH-bit words from the adapter over a valid/ready handshake and buffers one word.
- Serializes each word as bit pairs on odat0/odat1, which drive that stage's idat0/idat1 inputs, plus a matching oddrctrl.
- Runs on the same launch clock as the IO flops.

---
 rtl/aibcr3_txdat_gearbox_if.sv | 12 +
 rtl/aibcr3_txdat_gearbox.sv | 89 ++++++++
 tb/tb_aibcr3_txdat_gearbox.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aibcr3_txdat_gearbox_if.sv
// Adapter-to-gearbox word handshake: idata/ivalid from the adapter, oready back.
// The adapter side uses the master modport and the gearbox uses the slave modport.
interface aibcr3_txdat_gearbox_if #(
   parameter int DWIDTH = 8
);
   logic [DWIDTH-1:0] idata;
   logic              ivalid;
   logic              oready;

   modport master (output idata, output ivalid, input oready);
   modport slave  (input idata, input ivalid, output oready);
endinterface

// File: rtl/aibcr3_txdat_gearbox.sv
// Parallel-to-DDR gearbox: buffers one word, then shifts it out LSB first as
// bit pairs (DDR) or duplicated single bits (SDR) toward the AIB TX IO stage.
module aibcr3_txdat_gearbox #(
   parameter int   DWIDTH   = 8,
   parameter logic IDLE_VAL = 1'b0
) (
   input  logic                         ilaunch_clk,
   input  logic                         irst,
   input  logic                         iddr_mode,
   input  logic                         itx_en,
   aibcr3_txdat_gearbox_if.slave        bus,
   output logic                         odat0,
   output logic                         odat1,
   output logic                         oddrctrl,
   output logic                         obusy,
   output logic                         ounderflow
);
   localparam int CW = $clog2(DWIDTH);
   localparam logic [CW-1:0] LAST_DDR = CW'(DWIDTH / 2 - 1);
   localparam logic [CW-1:0] LAST_SDR = CW'(DWIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [DWIDTH-1:0] hold_data;
   logic [DWIDTH-1:0] shift_data;
   logic              hold_vld;
   logic              mode;
   logic [CW-1:0]     slot_cnt;
   logic              last_slot;
   logic              load;
   logic              xfer;

   // Bits presented for the slot at the bottom of a word: {odat1, odat0}.
   function automatic logic [1:0] slot_bits(input logic [DWIDTH-1:0] d, input logic ddr);
      return ddr ? {d[1], d[0]} : {d[0], d[0]};
   endfunction

   function automatic logic [DWIDTH-1:0] advance(input logic [DWIDTH-1:0] d, input logic ddr);
      return ddr ? (d >> 2) : (d >> 1);
   endfunction

   assign last_slot  = (state == SHIFT) && (slot_cnt == (mode ? LAST_DDR : LAST_SDR));
   assign load       = hold_vld && itx_en && ((state == IDLE) || last_slot);
   assign bus.oready = !irst && (!hold_vld || load);
   assign xfer       = bus.ivalid && bus.oready;
   assign oddrctrl   = mode;
   assign obusy      = (state == SHIFT);

   always_ff @(posedge ilaunch_clk) begin
      if (irst) begin
         state      <= IDLE;
         hold_vld   <= 1'b0;
         mode       <= 1'b1;
         slot_cnt   <= '0;
         odat0      <= IDLE_VAL;
         odat1      <= IDLE_VAL;
         ounderflow <= 1'b0;
      end else begin
         ounderflow <= 1'b0;

         if (xfer) begin
            hold_data <= bus.idata;
            hold_vld  <= 1'b1;
         end else if (load) begin
            hold_vld  <= 1'b0;
         end

         // shift_data always holds the not-yet-presented remainder of the word,
         // so the outputs for the next slot come straight from its bottom bits.
         if (load) begin
            state          <= SHIFT;
            mode           <= iddr_mode;
            slot_cnt       <= '0;
            shift_data     <= advance(hold_data, iddr_mode);
            {odat1, odat0} <= slot_bits(hold_data, iddr_mode);
         end else if (last_slot) begin
            state      <= IDLE;
            odat0      <= IDLE_VAL;
            odat1      <= IDLE_VAL;
            ounderflow <= itx_en && !hold_vld;
         end else if (state == SHIFT) begin
            slot_cnt       <= slot_cnt + 1'b1;
            shift_data     <= advance(shift_data, mode);
            {odat1, odat0} <= slot_bits(shift_data, mode);
         end
      end
   end
endmodule

// File: tb/tb_aibcr3_txdat_gearbox.sv
// Directed bench for aibcr3_txdat_gearbox with a word/slot-queue reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_aibcr3_txdat_gearbox;
   localparam int   DW       = 8;
   localparam logic IDLE_VAL = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic iddr_mode = 1'b1;
   logic itx_en = 1'b1;
   logic odat0, odat1, oddrctrl, obusy, ounderflow;

   aibcr3_txdat_gearbox_if #(.DWIDTH(DW)) bus ();

   aibcr3_txdat_gearbox #(.DWIDTH(DW), .IDLE_VAL(IDLE_VAL)) dut (
      .ilaunch_clk (clk),
      .irst        (rst),
      .iddr_mode   (iddr_mode),
      .itx_en      (itx_en),
      .bus         (bus),
      .odat0       (odat0),
      .odat1       (odat1),
      .oddrctrl    (oddrctrl),
      .obusy       (obusy),
      .ounderflow  (ounderflow)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Reference model: a one-word buffer and a queue of the slots still to be shown.
   logic [1:0]    q[$];
   logic [DW-1:0] m_hold_data;
   bit            m_hold_vld = 1'b0;
   bit            m_busy = 1'b0;
   logic [1:0]    m_out = {IDLE_VAL, IDLE_VAL};
   logic          m_ddr = 1'b1;
   logic          m_unf = 1'b0;

   always @(posedge clk) begin : model
      bit ended, ld, rdy, xf;
      if (rst) begin
         m_hold_vld = 1'b0;
         q.delete();
         m_busy = 1'b0;
         m_out  = {IDLE_VAL, IDLE_VAL};
         m_ddr  = 1'b1;
         m_unf  = 1'b0;
      end else begin
         ended = m_busy && (q.size() == 0);
         ld    = m_hold_vld && itx_en && (!m_busy || ended);
         rdy   = !m_hold_vld || ld;
         xf    = bus.ivalid && rdy;
         m_unf = 1'b0;
         if (ld) begin
            q.delete();
            for (int k = 0; k < (iddr_mode ? DW / 2 : DW); k++) begin
               if (iddr_mode) q.push_back({m_hold_data[2*k+1], m_hold_data[2*k]});
               else           q.push_back({m_hold_data[k], m_hold_data[k]});
            end
            m_out  = q.pop_front();
            m_ddr  = iddr_mode;
            m_busy = 1'b1;
         end else if (ended) begin
            m_busy = 1'b0;
            m_out  = {IDLE_VAL, IDLE_VAL};
            m_unf  = itx_en && !m_hold_vld;
         end else if (m_busy) begin
            m_out = q.pop_front();
         end
         if (xf) begin
            m_hold_data = bus.idata;
            m_hold_vld  = 1'b1;
         end else if (ld) begin
            m_hold_vld = 1'b0;
         end
      end
   end

   function automatic logic exp_ready();
      return !rst && (!m_hold_vld || (itx_en && (!m_busy || q.size() == 0)));
   endfunction

   always @(negedge clk) begin
      logic [5:0] act, exp;
      if (chk_en) begin
         act = {odat1, odat0, oddrctrl, obusy, ounderflow, bus.oready};
         exp = {m_out, m_ddr, m_busy, m_unf, exp_ready()};
         n_cmp++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t got %b want %b (odat1,odat0,ddrctrl,busy,unf,ready)",
                     $time, act, exp);
         end
      end
   end

   int run = 0, max_run = 0, unf_cnt = 0;
   always @(negedge clk) begin
      if (ounderflow === 1'b1) unf_cnt++;
      if (obusy === 1'b1) run++;
      else begin
         if (run > max_run) max_run = run;
         run = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Presents w with ivalid high and returns just after the edge that accepts it.
   task automatic send(input logic [7:0] w);
      int i;
      bus.idata  = w;
      bus.ivalid = 1'b1;
      #1;
      i = 0;
      while (bus.oready !== 1'b1 && i < 40) begin
         tick();
         i++;
      end
      if (bus.oready !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: word %h not accepted, oready %b want 1", w, bus.oready);
      end
      tick();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   logic [7:0] cap0, cap1;

   initial begin
      bus.ivalid = 1'b0;
      bus.idata  = '0;
      ticks(2);
      chk_en = 1'b1;
      lit("reset_outputs", {3'b0, odat1, odat0, oddrctrl, obusy, ounderflow}, 8'b000_00100);
      lit("reset_ready", {7'b0, bus.oready}, 8'h00);
      rst = 1'b0;
      #1;
      lit("ready_after_reset", {7'b0, bus.oready}, 8'h01);

      // DDR word 0xB4 followed by an underflow pulse.
      send(8'hB4);
      bus.ivalid = 1'b0;
      tick();
      lit("b4_slot0", {4'b0, odat0, odat1, oddrctrl, obusy}, 8'b0000_0011);
      tick();
      lit("b4_slot1", {4'b0, odat0, odat1, oddrctrl, obusy}, 8'b0000_1011);
      tick();
      lit("b4_slot2", {4'b0, odat0, odat1, oddrctrl, obusy}, 8'b0000_1111);
      tick();
      lit("b4_slot3", {4'b0, odat0, odat1, oddrctrl, obusy}, 8'b0000_0111);
      tick();
      lit("b4_underflow", {4'b0, odat0, odat1, obusy, ounderflow}, 8'b0000_0001);
      tick();
      lit("b4_underflow_end", {7'b0, ounderflow}, 8'h00);

      // Back-to-back DDR stream of three words.
      max_run = 0;
      unf_cnt = 0;
      send(8'h01);
      send(8'hFF);
      send(8'h5A);
      bus.ivalid = 1'b0;
      ticks(14);
      lit("stream_busy_run", max_run[7:0], 8'd12);
      lit("stream_underflows", unf_cnt[7:0], 8'd1);

      // SDR word 0xA5.
      iddr_mode = 1'b0;
      send(8'hA5);
      bus.ivalid = 1'b0;
      tick();
      for (int k = 0; k < 8; k++) begin
         cap0[k] = odat0;
         cap1[k] = odat1;
         if (k == 0) lit("sdr_ddrctrl", {7'b0, oddrctrl}, 8'h00);
         tick();
      end
      lit("sdr_odat0", cap0, 8'hA5);
      lit("sdr_odat1", cap1, 8'hA5);
      ticks(2);

      // Mode change mid-word applies only to the following word.
      iddr_mode = 1'b1;
      send(8'h3C);
      send(8'hC3);
      bus.ivalid = 1'b0;
      tick();
      iddr_mode = 1'b0;
      tick();
      lit("mode_slot2_ddr", {7'b0, oddrctrl}, 8'h01);
      tick();
      lit("mode_slot3_ddr", {7'b0, oddrctrl}, 8'h01);
      tick();
      lit("mode_second_word", {4'b0, odat0, odat1, oddrctrl, obusy}, 8'b0000_1101);
      ticks(9);
      iddr_mode = 1'b1;

      // itx_en dropped mid-word with a word waiting in hold.
      send(8'h96);
      send(8'h69);
      bus.ivalid = 1'b0;
      tick();
      tick();
      itx_en = 1'b0;
      tick();
      tick();
      lit("txen_off_idle", {3'b0, odat0, odat1, obusy, ounderflow, bus.oready}, 8'h00);
      tick();
      lit("txen_off_hold", {6'b0, obusy, bus.oready}, 8'h00);
      itx_en = 1'b1;
      #1;
      lit("txen_on_ready", {7'b0, bus.oready}, 8'h01);
      tick();
      lit("txen_on_load", {5'b0, odat0, odat1, obusy}, 8'b0000_0101);
      ticks(5);

      // Reset in slot 1, then a fresh word.
      send(8'h5A);
      bus.ivalid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      lit("rst_ready_low", {7'b0, bus.oready}, 8'h00);
      tick();
      lit("rst_mid_word", {3'b0, odat1, odat0, oddrctrl, obusy, ounderflow}, 8'b000_00100);
      rst = 1'b0;
      #1;
      lit("rst_hold_empty", {7'b0, bus.oready}, 8'h01);
      tick();
      lit("rst_no_underflow", {7'b0, ounderflow}, 8'h00);
      send(8'hE1);
      bus.ivalid = 1'b0;
      tick();
      lit("post_rst_slot0", {5'b0, odat0, odat1, obusy}, 8'b0000_0101);
      ticks(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
